// File: rtl/multiplication_dispatcher_pkg.sv
// multiplication_dispatcher_pkg: FSM states, default FIFO entry layout and default sizes.
// The entry carries a tag field only when MULTIPLICATION_DISPATCHER_TAG_EN is defined.
package multiplication_dispatcher_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESPOND} state_t;
  typedef struct packed {
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
    logic [DEF_TAG_WIDTH-1:0] tag;
`endif
    logic [DEF_WIDTH-1:0] multiplicand;
    logic [DEF_WIDTH-1:0] multiplier;
  } entry_t;
endpackage

// File: rtl/dispatcher_fifo.sv
// dispatcher_fifo: power-of-two synchronous FIFO with occupancy count.
// The entry layout is a type parameter so the dispatcher can size it from its own WIDTH.
module dispatcher_fifo
  import multiplication_dispatcher_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter type data_t = entry_t
) (
  input  logic                         clock,
  input  logic                         reset_in,
  input  logic                         push,
  input  logic                         pop,
  input  data_t                        wdata,
  output data_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  data_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= wdata;
  // Pointers are AW bits wide, so wrapping modulo DEPTH is free.
  always_ff @(posedge clock or negedge reset_in)
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/multiplication_dispatcher.sv
// multiplication_dispatcher: queues operand pairs and runs them one at a time through the
// sequential multiplicator; tag ports exist only with MULTIPLICATION_DISPATCHER_TAG_EN.
module multiplication_dispatcher
  import multiplication_dispatcher_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
`endif
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_in,
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
  input  logic [TAG_WIDTH-1:0]         req_tag_in,
  output logic [TAG_WIDTH-1:0]         rsp_tag_out,
`endif
  input  logic                         req_valid_in,
  output logic                         req_ready_out,
  input  logic [WIDTH-1:0]             req_multiplicand_in,
  input  logic [WIDTH-1:0]             req_multiplier_in,
  output logic                         mul_start_out,
  output logic [WIDTH-1:0]             mul_multiplicand_out,
  output logic [WIDTH-1:0]             mul_multiplier_out,
  input  logic                         mul_done_in,
  input  logic [2*WIDTH-1:0]           mul_product_in,
  input  logic                         mul_overflow_in,
  output logic                         rsp_valid_out,
  input  logic                         rsp_ready_in,
  output logic [2*WIDTH-1:0]           rsp_product_out,
  output logic                         rsp_overflow_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);
  typedef struct packed {
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
    logic [TAG_WIDTH-1:0] tag;
`endif
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
  } job_t;
  state_t state, state_nx;
  job_t wdata, head;
  logic full, empty, pop, done_q, done_rise;
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q;
`endif
  always_comb begin
    wdata.multiplicand = req_multiplicand_in;
    wdata.multiplier = req_multiplier_in;
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
    wdata.tag = req_tag_in;
`endif
  end
  assign req_ready_out = !full;
  assign pop = (state == IDLE) && !empty;
  // Edge, not level: a done still high from the previous job must not complete this one.
  assign done_rise = mul_done_in && !done_q;
  dispatcher_fifo #(.DEPTH(DEPTH), .data_t(job_t)) u_fifo (
    .clock,
    .reset_in,
    .push  (req_valid_in),
    .pop,
    .wdata,
    .rdata (head),
    .full,
    .empty,
    .count (count_out)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = done_rise ? RESPOND : WAIT;
      RESPOND: state_nx = rsp_ready_in ? IDLE : RESPOND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_in)
    if (!reset_in) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_in)
    if (!reset_in) begin
      done_q <= 1'b0;
      mul_start_out <= 1'b0;
      mul_multiplicand_out <= '0;
      mul_multiplier_out <= '0;
      rsp_valid_out <= 1'b0;
      rsp_product_out <= '0;
      rsp_overflow_out <= 1'b0;
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
      tag_q <= '0;
      rsp_tag_out <= '0;
`endif
    end else begin
      done_q <= mul_done_in;
      mul_start_out <= pop;
      if (pop) begin
        mul_multiplicand_out <= head.multiplicand;
        mul_multiplier_out <= head.multiplier;
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
        tag_q <= head.tag;
`endif
      end
      if (state == WAIT && done_rise) begin
        rsp_valid_out <= 1'b1;
        rsp_product_out <= mul_product_in;
        rsp_overflow_out <= mul_overflow_in;
`ifdef MULTIPLICATION_DISPATCHER_TAG_EN
        rsp_tag_out <= tag_q;
`endif
      end else if (state == RESPOND && rsp_ready_in) begin
        rsp_valid_out <= 1'b0;
      end
    end
endmodule
